pll_reset_sequencer: RTL and testbench

Supervises the on-chip PLL from the free-running 50 MHz reference clock. It drives the PLL's active-high reset, synchronizes and qualifies the PLL `locked` output, and releases the system reset only after lock has been stable for a programmable time. It re-sequences the PLL on lock timeout, loss of lock, or software request, and keeps saturating event counters for diagnostics. It sits directly upstream and downstream of the PLL wrapper: it feeds that wrapper's `rst` and consumes its `locked`.

---
 rtl/pll_seq_pkg.sv | 28 ++
 rtl/sync_bit.sv | 24 ++
 rtl/pll_reset_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RST = 2'd0,
    WAIT    = 2'd1,
    STABLE  = 2'd2,
    RUN     = 2'd3
  } pll_seq_state_t;

  localparam int DEF_RST_PULSE_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_SYNC_STAGES         = 2;
  localparam int DEF_CNT_W               = 8;

  // Width of the shared state counter: enough to reach the largest cycle count.
  function automatic int seq_cnt_width(input int a, input int b, input int c);
    int m;
    int w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit; flops reset to 0.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_ff;

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= {STAGES{1'b0}};
    end else begin
      sync_ff <= {sync_ff[STAGES-2:0], d};
    end
  end

  assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Supervises the PLL: pulses its reset, qualifies lock, and releases the
// system reset once lock has been stable; re-sequences on timeout, lock
// loss or software request and keeps saturating diagnostic counters.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
  parameter int CNT_W               = DEF_CNT_W
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             relock_req,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             ready,
  output logic [CNT_W-1:0] lock_loss_count,
  output logic [CNT_W-1:0] timeout_count
);

  localparam int CW = seq_cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam logic [CW-1:0]    RST_LAST    = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0]    TO_LAST     = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]    STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0]    CNT_ONE     = CW'(1);
  localparam logic [CNT_W-1:0] EV_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] EV_ONE      = CNT_W'(1);

  pll_seq_state_t state;
  pll_seq_state_t next_state;
  logic [CW-1:0]  cnt;
  logic           locked_s;
  logic           cnt_clear;
  logic           timeout_hit;
  logic           loss_hit;
  logic           pll_rst_d;
  logic           sys_rst_n_d;
  logic           ready_d;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  // State register.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PLL_RST;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a relock request overrides every other transition.
  always_comb begin
    next_state  = state;
    cnt_clear   = 1'b0;
    timeout_hit = 1'b0;
    loss_hit    = 1'b0;
    if (relock_req) begin
      next_state = PLL_RST;
      cnt_clear  = 1'b1;
    end else begin
      case (state)
        PLL_RST: begin
          if (cnt == RST_LAST) begin
            next_state = WAIT;
            cnt_clear  = 1'b1;
          end else begin
            next_state = PLL_RST;
          end
        end
        WAIT: begin
          if (locked_s) begin
            next_state = STABLE;
            cnt_clear  = 1'b1;
          end else if (cnt == TO_LAST) begin
            next_state  = PLL_RST;
            cnt_clear   = 1'b1;
            timeout_hit = 1'b1;
          end else begin
            next_state = WAIT;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            next_state = WAIT;
            cnt_clear  = 1'b1;
          end else if (cnt == STABLE_LAST) begin
            next_state = RUN;
            cnt_clear  = 1'b1;
          end else begin
            next_state = STABLE;
          end
        end
        RUN: begin
          if (!locked_s) begin
            next_state = PLL_RST;
            cnt_clear  = 1'b1;
            loss_hit   = 1'b1;
          end else begin
            next_state = RUN;
          end
        end
        default: begin
          next_state = PLL_RST;
          cnt_clear  = 1'b1;
        end
      endcase
    end
  end

  // Output decode from the state being entered, so the flopped outputs track the state register.
  always_comb begin
    pll_rst_d   = 1'b1;
    sys_rst_n_d = 1'b0;
    ready_d     = 1'b0;
    case (next_state)
      PLL_RST: begin
        pll_rst_d   = 1'b1;
        sys_rst_n_d = 1'b0;
        ready_d     = 1'b0;
      end
      WAIT, STABLE: begin
        pll_rst_d   = 1'b0;
        sys_rst_n_d = 1'b0;
        ready_d     = 1'b0;
      end
      RUN: begin
        pll_rst_d   = 1'b0;
        sys_rst_n_d = 1'b1;
        ready_d     = 1'b1;
      end
      default: begin
        pll_rst_d   = 1'b1;
        sys_rst_n_d = 1'b0;
        ready_d     = 1'b0;
      end
    endcase
  end

  // Registered Moore outputs; reset forces the safe values asynchronously.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
    end else begin
      pll_rst   <= pll_rst_d;
      sys_rst_n <= sys_rst_n_d;
      ready     <= ready_d;
    end
  end

  // Shared cycle counter, cleared on every transition and idle in RUN.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= {CW{1'b0}};
    end else if (cnt_clear) begin
      cnt <= {CW{1'b0}};
    end else if (state == RUN) begin
      cnt <= cnt;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Saturating count of lock losses seen while running.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_loss_count <= {CNT_W{1'b0}};
    end else if (loss_hit && (lock_loss_count != EV_MAX)) begin
      lock_loss_count <= lock_loss_count + EV_ONE;
    end else begin
      lock_loss_count <= lock_loss_count;
    end
  end

  // Saturating count of lock timeouts.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_count <= {CNT_W{1'b0}};
    end else if (timeout_hit && (timeout_count != EV_MAX)) begin
      timeout_count <= timeout_count + EV_ONE;
    end else begin
      timeout_count <= timeout_count;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: stimulus pushes expected output
// events (cycle stamp + output values); a monitor pops and compares each time
// the DUT outputs change or an explicit probe is requested.
module tb_pll_reset_sequencer;

  logic       refclk     = 1'b0;
  logic       rst_n      = 1'b0;
  logic       pll_locked = 1'b1;
  logic       relock_req = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic [3:0] lock_loss_count;
  logic [3:0] timeout_count;

  typedef struct {
    int         cyc;
    logic       pr;
    logic       sr;
    logic       rd;
    logic [3:0] ll;
    logic [3:0] to;
  } ev_t;

  ev_t   exp_q[$];
  int    cyc       = 0;
  int    n_checks  = 0;
  int    n_fail    = 0;
  bit    probe_tog = 1'b0;
  bit    last_tog;
  logic [10:0] last_v;
  logic [10:0] cur_v;
  logic [10:0] exp_v;
  ev_t   e;

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .LOCK_STABLE_CYCLES  (8),
    .SYNC_STAGES         (2),
    .CNT_W               (4)
  ) dut (
    .refclk          (refclk),
    .rst_n           (rst_n),
    .pll_locked      (pll_locked),
    .relock_req      (relock_req),
    .pll_rst         (pll_rst),
    .sys_rst_n       (sys_rst_n),
    .ready           (ready),
    .lock_loss_count (lock_loss_count),
    .timeout_count   (timeout_count)
  );

  always #5 refclk = ~refclk;

  always @(posedge refclk) cyc <= cyc + 1;

  function automatic void push(input int c, input logic pr, input logic sr, input logic rd,
                               input int ll, input int to);
    ev_t x;
    x.cyc = c;
    x.pr  = pr;
    x.sr  = sr;
    x.rd  = rd;
    x.ll  = 4'(ll);
    x.to  = 4'(to);
    exp_q.push_back(x);
  endfunction

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // Full re-sequence from PLL_RST entered (cnt 0) at cycle p with lock held.
  function automatic void seq_from(input int p, input int ll, input int to);
    push(p + 4, 1'b0, 1'b0, 1'b0, ll, to);
    push(p + 13, 1'b0, 1'b1, 1'b1, ll, to);
  endfunction

  task automatic to_neg(input int n);
    if (cyc > n) begin
      n_fail++;
      $display("FAIL schedule: at cycle %0d, wanted cycle %0d", cyc, n);
    end
    while (cyc < n) @(negedge refclk);
  endtask

  // Assert rst_n asynchronously 3 ns after the edge that starts cycle n.
  task automatic async_rst_at(input int n);
    to_neg(n - 1);
    @(posedge refclk);
    #3;
    push(n, 1'b1, 1'b0, 1'b0, 0, 0);
    rst_n = 1'b0;
  endtask

  // Monitor: compare every output change (or probe) against the queue head.
  initial begin
    last_v   = {1'b1, 1'b0, 1'b0, 4'd0, 4'd0};
    last_tog = 1'b0;
    forever begin
      @(pll_rst or sys_rst_n or ready or lock_loss_count or timeout_count or probe_tog);
      #1;
      cur_v = {pll_rst, sys_rst_n, ready, lock_loss_count, timeout_count};
      if ((cur_v !== last_v) || (probe_tog != last_tog)) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: cycle %0d got pr/sr/rd/ll/to=%b none expected", cyc, cur_v);
        end else begin
          e = exp_q.pop_front();
          exp_v = {e.pr, e.sr, e.rd, e.ll, e.to};
          if ((e.cyc != cyc) || (cur_v !== exp_v)) begin
            n_fail++;
            $display("FAIL output_event: got cycle %0d pr=%b sr=%b rd=%b ll=%0d to=%0d, expected cycle %0d pr=%b sr=%b rd=%b ll=%0d to=%0d",
                     cyc, cur_v[10], cur_v[9], cur_v[8], cur_v[7:4], cur_v[3:0],
                     e.cyc, e.pr, e.sr, e.rd, e.ll, e.to);
          end
        end
      end
      last_v   = cur_v;
      last_tog = probe_tog;
    end
  end

  initial begin
    // Reset state, then best-case bring-up with lock present from time 0.
    to_neg(3);
    push(3, 1'b1, 1'b0, 1'b0, 0, 0);
    probe_tog = ~probe_tog;
    seq_from(3, 0, 0);
    rst_n = 1'b1;

    // Software relock from RUN.
    to_neg(20);
    push(21, 1'b1, 1'b0, 1'b0, 0, 0);
    seq_from(21, 0, 0);
    relock_req = 1'b1;
    to_neg(21);
    relock_req = 1'b0;

    // Lock loss in RUN: three edges to PLL reset, loss counted, then re-lock.
    to_neg(38);
    pll_locked = 1'b0;
    push(41, 1'b1, 1'b0, 1'b0, 1, 0);
    seq_from(41, 1, 0);
    to_neg(41);
    pll_locked = 1'b1;

    // Lock loss and relock in the same cycle: loss not counted.
    to_neg(58);
    pll_locked = 1'b0;
    to_neg(60);
    relock_req = 1'b1;
    push(61, 1'b1, 1'b0, 1'b0, 1, 0);
    seq_from(61, 1, 0);
    to_neg(61);
    relock_req = 1'b0;
    pll_locked = 1'b1;

    // Lock glitch in STABLE at count 5: back to WAIT, full 8 stable cycles afterwards.
    to_neg(78);
    relock_req = 1'b1;
    push(79, 1'b1, 1'b0, 1'b0, 1, 0);
    push(83, 1'b0, 1'b0, 1'b0, 1, 0);
    push(101, 1'b0, 1'b1, 1'b1, 1, 0);
    to_neg(79);
    relock_req = 1'b0;
    to_neg(87);
    pll_locked = 1'b0;
    to_neg(90);
    pll_locked = 1'b1;

    // No lock: 4 high / 20 low pulses, timeout counter saturates at 15.
    to_neg(105);
    relock_req = 1'b1;
    pll_locked = 1'b0;
    push(106, 1'b1, 1'b0, 1'b0, 1, 0);
    for (int k = 0; k <= 16; k++) begin
      push(106 + 24 * k + 4, 1'b0, 1'b0, 1'b0, 1, sat15(k));
      push(106 + 24 * (k + 1), 1'b1, 1'b0, 1'b0, 1, sat15(k + 1));
    end
    push(106 + 24 * 17 + 4, 1'b0, 1'b0, 1'b0, 1, 15);
    to_neg(106);
    relock_req = 1'b0;
    to_neg(520);
    relock_req = 1'b1;
    pll_locked = 1'b1;
    push(521, 1'b1, 1'b0, 1'b0, 1, 15);
    push(525, 1'b0, 1'b0, 1'b0, 1, 15);
    to_neg(521);
    relock_req = 1'b0;

    // Asynchronous reset mid-STABLE, then bring-up, then asynchronous reset mid-RUN.
    async_rst_at(529);
    to_neg(531);
    seq_from(531, 0, 0);
    rst_n = 1'b1;
    async_rst_at(548);
    to_neg(552);

    for (int i = 0; (i < 50) && (exp_q.size() != 0); i++) @(negedge refclk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected events never seen, next expected at cycle %0d",
               exp_q.size(), exp_q[0].cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
